// File: rtl/jt12_phrom_arb.sv
// jt12_phrom_arb: round-robin arbiter sharing one registered 32x46 phase ROM
// between NREQ requesters (operator pipe, test reader, LFO, ...).
// Ports: clk, rst (sync, active high), clk_en; req/addr from requesters;
// gnt/rd_valid one-clk pulses per requester; rd_data passes rom_ph through;
// rom_addr drives the ROM; rom_ph comes back from it; busy = read in flight.
// Option: define JT12_PHROM_PRIO0_EN to give requester 0 fixed top priority.
module jt12_phrom_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rd_valid,
  output logic [45:0]       rd_data,
  output logic [4:0]        rom_addr,
  input  logic [45:0]       rom_ph,
  output logic              busy
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_vld_q, s1_vld_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_vld_q, s2_vld_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [4:0]      addr_q, addr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rdv_q, rdv_d;

  logic            hit;
  logic            upd;
  logic [IDW-1:0]  win;
  logic [4:0]      win_addr;

  // Winner = set request with the smallest distance from the pointer.
  always_comb begin
    int best;
    int d;
    best = NREQ;
    d    = 0;
    hit  = 1'b0;
    upd  = 1'b0;
    win  = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(ptr_q);
      if (d < 0) d = d + NREQ;
      if (req[i] && d < best) begin
        best = d;
        win  = IDW'(i);
        hit  = 1'b1;
        upd  = 1'b1;
      end
    end
`ifdef JT12_PHROM_PRIO0_EN
    // Requester 0 overrides rotation and leaves the pointer alone.
    if (req[0]) begin
      win = '0;
      hit = 1'b1;
      upd = 1'b0;
    end
`endif
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(win) == i) win_addr = addr[5*i +: 5];
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    s1_vld_d = s1_vld_q;
    s1_id_d  = s1_id_q;
    s2_vld_d = s2_vld_q;
    s2_id_d  = s2_id_q;
    addr_d   = addr_q;
    gnt_d    = '0;
    rdv_d    = '0;
    if (clk_en) begin
      s1_vld_d = hit;
      s1_id_d  = win;
      s2_vld_d = s1_vld_q;
      s2_id_d  = s1_id_q;
      if (hit) begin
        addr_d = win_addr;
        if (upd) begin
          if (int'(win) == NREQ - 1) ptr_d = '0;
          else ptr_d = win + 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        gnt_d[i] = hit && (int'(win) == i);
        rdv_d[i] = s1_vld_q && (int'(s1_id_q) == i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_id_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= '0;
      addr_q   <= '0;
      gnt_q    <= '0;
      rdv_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      s1_vld_q <= s1_vld_d;
      s1_id_q  <= s1_id_d;
      s2_vld_q <= s2_vld_d;
      s2_id_q  <= s2_id_d;
      addr_q   <= addr_d;
      gnt_q    <= gnt_d;
      rdv_q    <= rdv_d;
    end
  end

  assign gnt      = gnt_q;
  assign rd_valid = rdv_q;
  assign rd_data  = rom_ph;
  assign rom_addr = addr_q;
  assign busy     = s1_vld_q | s2_vld_q;

endmodule
